// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle IF/ID/EXE/MEM/WB sequencer for SRAMs with configurable read latency.
// Define MC_PERF_CNT_EN to build the cycle and retired-instruction counters; otherwise both read 0.
module mc_ctrl #(
    parameter int          INST_LAT = 1,
    parameter int          DATA_LAT = 1,
    parameter logic [31:0] PC_RESET = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_sram_rdata,
    input  logic        is_br_only,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        gr_we,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_sram_en,
    output logic        data_sram_en,
    output logic        data_sram_we,
    output logic        rf_we,
    output logic [2:0]  state,
    output logic        retire,
    output logic [31:0] debug_wb_pc,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [3:0] I_LAST = 4'(INST_LAT - 1);
    localparam logic [3:0] D_LAST = 4'(DATA_LAT - 1);

    state_t      state_q;
    logic [31:0] pc_q, ir_q, npc_q;
    logic [3:0]  wcnt_q;
    logic [31:0] br_pc;
    logic        i_done, d_done;

    assign br_pc  = br_taken ? br_target : pc_q + 32'd4;
    assign i_done = wcnt_q == I_LAST;
    assign d_done = wcnt_q == D_LAST;

    // Strobes are gated by reset so an aborted instruction never writes or retires.
    assign inst_sram_en = !reset && state_q == S_IF;
    assign data_sram_en = !reset && state_q == S_MEM;
    assign data_sram_we = data_sram_en && is_store && wcnt_q == 4'd0;
    assign rf_we        = !reset && state_q == S_WB && gr_we;
    assign retire       = !reset && ((state_q == S_ID && is_br_only) ||
                                     (state_q == S_MEM && is_store && d_done) ||
                                     state_q == S_WB);
    assign pc           = pc_q;
    assign debug_wb_pc  = pc_q;
    assign state        = state_q;
    assign inst         = state_q == S_ID ? inst_sram_rdata : ir_q;

    // Sequencer: state, wait counter, PC, instruction register and latched next PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
            npc_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            case (state_q)
                S_IF: begin
                    wcnt_q  <= i_done ? 4'd0 : wcnt_q + 4'd1;
                    state_q <= i_done ? S_ID : S_IF;
                end
                S_ID: begin
                    ir_q    <= inst_sram_rdata;
                    npc_q   <= br_pc;
                    if (is_br_only) pc_q <= br_pc;
                    state_q <= is_br_only ? S_IF : S_EXE;
                end
                S_EXE: state_q <= (is_load | is_store) ? S_MEM : S_WB;
                S_MEM: begin
                    wcnt_q <= d_done ? 4'd0 : wcnt_q + 4'd1;
                    if (d_done && is_store) pc_q <= npc_q;
                    if (d_done) state_q <= is_store ? S_IF : S_WB;
                end
                S_WB: begin
                    pc_q    <= npc_q;
                    state_q <= S_IF;
                end
                default: begin
                    state_q <= S_IF;
                    wcnt_q  <= '0;
                end
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_q, ret_q;

    // Free-running cycle counter and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            ret_q <= ret_q + {31'd0, retire};
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif
endmodule
